// File: rtl/fir_lane_array.sv
// HEVC luma sub-pixel FIR, LANES outputs per beat. Window, products, sum and output are each registered (accept edge N -> out_valid after N+3).
// One global advance enable; in_ready = !(out_valid && !out_ready), so a stall freezes every stage and the output.
module fir_lane_array #(
  parameter int LANES       = 8,
  parameter int IN_W        = 16,
  parameter int OUT_W       = 16,
  parameter int PIX_W       = 8,
  parameter int INTER_SHIFT = 0,
  parameter int FINAL_SHIFT = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(LANES+7)*IN_W-1:0]   in_samples,
  input  logic [1:0]                  in_frac,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*OUT_W-1:0]      out_samples,
  output logic                        out_last,
  output logic [15:0]                 beat_count
);

  localparam int TAPS  = 8;
  localparam int WIN   = LANES + 7;
  localparam int ACC_W = IN_W + 8;

  localparam logic signed [7:0] COEF [4][TAPS] = '{
    '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0},
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1},
    '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1}
  };

  localparam logic signed [ACC_W:0] RND      = (ACC_W+1)'(2**(FINAL_SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(2**(OUT_W-1)));
  localparam logic signed [ACC_W:0] CLIP_MAX = (ACC_W+1)'(2**PIX_W - 1);

  typedef struct packed {
    logic [1:0] frac;
    logic       mode;
    logic       last;
  } meta_t;

  typedef struct packed {
    logic mode;
    logic last;
  } tail_t;

  logic                      stall;
  logic                      advance;

  logic                      s0_vld;
  logic [WIN*IN_W-1:0]       s0_win;
  meta_t                     s0_meta;

  logic                      s1_vld;
  logic signed [ACC_W-1:0]   s1_prod [LANES][TAPS];
  tail_t                     s1_meta;

  logic                      s2_vld;
  logic signed [ACC_W-1:0]   s2_sum [LANES];
  tail_t                     s2_meta;

  logic signed [ACC_W-1:0]   prod_c [LANES][TAPS];
  logic signed [ACC_W-1:0]   sum_c  [LANES];
  logic [LANES*OUT_W-1:0]    res_c;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;

  // Stage valids carry reset; data registers only load real beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld <= 1'b0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (advance) begin
      s0_vld <= in_valid;
      s1_vld <= s0_vld;
      s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s0_win  <= in_samples;
      s0_meta <= '{frac: in_frac, mode: in_mode, last: in_last};
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < TAPS; j++) begin
        prod_c[k][j] = ACC_W'($signed(s0_win[(k+j)*IN_W +: IN_W])) * ACC_W'(COEF[s0_meta.frac][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && s0_vld) begin
      s1_prod <= prod_c;
      s1_meta <= '{mode: s0_meta.mode, last: s0_meta.last};
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sum_c[k] = ((s1_prod[k][0] + s1_prod[k][1]) + (s1_prod[k][2] + s1_prod[k][3]))
               + ((s1_prod[k][4] + s1_prod[k][5]) + (s1_prod[k][6] + s1_prod[k][7]));
    end
  end

  always_ff @(posedge clk) begin
    if (advance && s1_vld) begin
      s2_sum  <= sum_c;
      s2_meta <= s1_meta;
    end
  end

  // Final mode rounds then clips to the pixel range; intermediate mode saturates to signed OUT_W.
  always_comb begin
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shf;
    logic signed [ACC_W:0] val;
    res_c = '0;
    for (int k = 0; k < LANES; k++) begin
      ext = {s2_sum[k][ACC_W-1], s2_sum[k]};
      if (s2_meta.mode) begin
        shf = (ext + RND) >>> FINAL_SHIFT;
        if (shf < 0)
          val = '0;
        else if (shf > CLIP_MAX)
          val = CLIP_MAX;
        else
          val = shf;
      end else begin
        shf = ext >>> INTER_SHIFT;
        if (shf > SAT_MAX)
          val = SAT_MAX;
        else if (shf < SAT_MIN)
          val = SAT_MIN;
        else
          val = shf;
      end
      res_c[k*OUT_W +: OUT_W] = val[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_samples <= '0;
      out_last    <= 1'b0;
      beat_count  <= 16'd0;
    end else begin
      if (advance) begin
        out_valid <= s2_vld;
        if (s2_vld) begin
          out_samples <= res_c;
          out_last    <= s2_meta.last;
        end
      end
      if (out_valid && out_ready)
        beat_count <= beat_count + 16'd1;
    end
  end

endmodule
